// File: rtl/t5_lsu.sv
// t5_lsu: load/store unit between execute and a Wishbone-style data bus.
// Runs one single transfer per access, and stalls the pipeline while that
// transfer is outstanding. Load data is returned aligned and sign/zero-extended.
// Misaligned addresses, illegal fn3 codes and bus timeouts are reported as
// one-cycle exception pulses.
module t5_lsu #(
  parameter int unsigned TOUT = 255
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        sena,
  input  logic [4:0]  xopc,
  input  logic [2:0]  xfn3,
  input  logic [31:0] xea,
  input  logic [31:0] xdat,
  output logic [29:0] dwb_adr_o,
  output logic [3:0]  dwb_sel_o,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_we_o,
  output logic        dwb_cyc_o,
  output logic        dwb_stb_o,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_ack_i,
  output logic [31:0] mdat,
  output logic        mld,
  output logic [1:0]  mexc,
  output logic        lsu_stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TLAST = 8'(TOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  lane;
  logic [2:0]  fn3_q;

  logic        is_ld;
  logic        is_st;
  logic        legal;
  logic        aligned;
  logic [3:0]  sel_c;
  logic [31:0] shf;
  logic [31:0] ext_c;

  // Decode the execute-stage request: access type, legality, alignment, lanes
  always_comb begin
    is_ld   = (xopc == 5'h00);
    is_st   = (xopc == 5'h08);
    legal   = 1'b0;
    aligned = 1'b0;
    sel_c   = '0;
    case (xfn3)
      3'b000, 3'b001, 3'b010: legal = is_ld | is_st;
      3'b100, 3'b101:         legal = is_ld;
      default:                legal = 1'b0;
    endcase
    case (xfn3[1:0])
      2'b00: begin
        aligned = 1'b1;
        sel_c   = 4'b0001 << xea[1:0];
      end
      2'b01: begin
        aligned = ~xea[0];
        sel_c   = xea[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        aligned = (xea[1:0] == 2'b00);
        sel_c   = 4'b1111;
      end
    endcase
  end

  // Pull the addressed byte/half down to bit 0 and extend it
  always_comb begin
    shf   = dwb_dat_i >> {lane, 3'b000};
    ext_c = dwb_dat_i;
    case (fn3_q[1:0])
      2'b00:   ext_c = fn3_q[2] ? {24'h000000, shf[7:0]}
                                : {{24{shf[7]}}, shf[7:0]};
      2'b01:   ext_c = fn3_q[2] ? {16'h0000, shf[15:0]}
                                : {{16{shf[15]}}, shf[15:0]};
      default: ext_c = dwb_dat_i;
    endcase
  end

  // Combinational so the pipeline advances on the same edge the ack lands
  assign lsu_stall = (state == BUSY) & ~dwb_ack_i;

  // Transfer FSM with registered bus signals, load result and exception pulses
  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state     <= IDLE;
      cnt       <= '0;
      lane      <= '0;
      fn3_q     <= '0;
      dwb_adr_o <= '0;
      dwb_sel_o <= '0;
      dwb_dat_o <= '0;
      dwb_we_o  <= 1'b0;
      dwb_cyc_o <= 1'b0;
      dwb_stb_o <= 1'b0;
      mdat      <= '0;
      mld       <= 1'b0;
      mexc      <= '0;
    end else begin
      mld  <= 1'b0;
      mexc <= '0;
      case (state)
        IDLE: begin
          if (sena && (is_ld || is_st)) begin
            if (legal && aligned) begin
              state     <= BUSY;
              cnt       <= '0;
              dwb_adr_o <= xea[31:2];
              dwb_sel_o <= sel_c;
              dwb_we_o  <= is_st;
              dwb_dat_o <= xdat;
              lane      <= xea[1:0];
              fn3_q     <= xfn3;
              dwb_cyc_o <= 1'b1;
              dwb_stb_o <= 1'b1;
            end else begin
              mexc <= 2'b01;
            end
          end
        end
        BUSY: begin
          if (dwb_ack_i) begin
            state     <= IDLE;
            dwb_cyc_o <= 1'b0;
            dwb_stb_o <= 1'b0;
            if (!dwb_we_o) begin
              mdat <= ext_c;
              mld  <= 1'b1;
            end
          end else if (cnt == TLAST) begin
            state     <= IDLE;
            dwb_cyc_o <= 1'b0;
            dwb_stb_o <= 1'b0;
            mexc      <= 2'b10;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t5_lsu.sv
// Bench for t5_lsu: directed vector table plus randomized accesses checked
// against a rule-level reference model, and hand sequences for reset/idle-ack.
module tb_t5_lsu;

  localparam int TO = 4;

  logic        sclk = 1'b0;
  logic        srst = 1'b0;
  logic        sena = 1'b0;
  logic [4:0]  xopc = 5'h1F;
  logic [2:0]  xfn3 = '0;
  logic [31:0] xea  = '0;
  logic [31:0] xdat = '0;
  logic [29:0] dwb_adr_o;
  logic [3:0]  dwb_sel_o;
  logic [31:0] dwb_dat_o;
  logic        dwb_we_o;
  logic        dwb_cyc_o;
  logic        dwb_stb_o;
  logic [31:0] dwb_dat_i = '0;
  logic        dwb_ack_i = 1'b0;
  logic [31:0] mdat;
  logic        mld;
  logic [1:0]  mexc;
  logic        lsu_stall;

  t5_lsu #(.TOUT(TO)) dut (
    .sclk(sclk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3),
    .xea(xea), .xdat(xdat), .dwb_adr_o(dwb_adr_o), .dwb_sel_o(dwb_sel_o),
    .dwb_dat_o(dwb_dat_o), .dwb_we_o(dwb_we_o), .dwb_cyc_o(dwb_cyc_o),
    .dwb_stb_o(dwb_stb_o), .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
    .mdat(mdat), .mld(mld), .mexc(mexc), .lsu_stall(lsu_stall)
  );

  always #5 sclk = ~sclk;

  // kind: 0 no access, 1 rejected (misaligned/illegal), 2 bus transfer
  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  fn3;
    logic [31:0] ea;
    logic [31:0] xd;
    logic [31:0] rd;
    int          waits;
    int          kind;
    logic [3:0]  sel;
    logic [31:0] md;
    logic        ld;
    logic [1:0]  exc;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdat_m = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model built from the access rules with plain arithmetic
  function automatic vec_t model(input logic [4:0] opc, input logic [2:0] fn3,
                                 input logic [31:0] ea, input logic [31:0] xd,
                                 input logic [31:0] rd, input int waits);
    vec_t v;
    int size, ofs;
    bit is_ld, is_st, legal, alig;
    logic [31:0] val;
    v.opc = opc; v.fn3 = fn3; v.ea = ea; v.xd = xd; v.rd = rd; v.waits = waits;
    v.sel = '0; v.md = '0; v.ld = 1'b0; v.exc = 2'b00;
    is_ld = (opc == 5'h00);
    is_st = (opc == 5'h08);
    legal = is_ld ? (fn3 == 0 || fn3 == 1 || fn3 == 2 || fn3 == 4 || fn3 == 5)
                  : (fn3 == 0 || fn3 == 1 || fn3 == 2);
    size = int'(fn3 % 4);
    ofs  = int'(ea % 4);
    alig = (size == 0) || (size == 1 && ofs % 2 == 0) || (size == 2 && ofs == 0);
    if (!(is_ld || is_st)) v.kind = 0;
    else if (!legal || !alig) begin v.kind = 1; v.exc = 2'b01; end
    else begin
      v.kind = 2;
      v.sel = (size == 0) ? 4'(1 << ofs) : (size == 1) ? ((ofs >= 2) ? 4'hC : 4'h3) : 4'hF;
      val = rd >> (ofs * 8);
      if (size == 0) begin
        val = val % 256;
        if (fn3 < 4 && val >= 128) val = val + 32'hFFFF_FF00;
      end else if (size == 1) begin
        val = val % 65536;
        if (fn3 < 4 && val >= 32768) val = val + 32'hFFFF_0000;
      end
      v.md = val;
      if (waits >= TO) v.exc = 2'b10;
      else v.ld = is_ld;
    end
    return v;
  endfunction

  task automatic run(input vec_t v, input bit noise);
    logic [31:0] expd;
    @(negedge sclk);
    sena = 1'b1; xopc = v.opc; xfn3 = v.fn3; xea = v.ea; xdat = v.xd; dwb_dat_i = v.rd;
    @(posedge sclk); #1;
    sena = 1'b0; xopc = 5'h1F;
    if (v.kind != 2) begin
      chk("nobus_cyc", dwb_cyc_o, 0);
      chk("nobus_stall", lsu_stall, 0);
      chk("nobus_mexc", mexc, (v.kind == 1) ? 1 : 0);
      chk("nobus_mld", mld, 0);
      @(posedge sclk); #1;
      chk("nobus_mexc_pulse", mexc, 0);
      chk("nobus_mdat", mdat, mdat_m);
      return;
    end
    chk("start_cyc", dwb_cyc_o, 1);
    chk("start_stb", dwb_stb_o, 1);
    chk("start_adr", dwb_adr_o, v.ea >> 2);
    chk("start_sel", dwb_sel_o, v.sel);
    chk("start_we", dwb_we_o, (v.opc == 5'h08) ? 1 : 0);
    if (v.opc == 5'h08) chk("start_dat", dwb_dat_o, v.xd);
    for (int k = 0; k < TO; k++) begin
      dwb_ack_i = (k == v.waits);
      if (noise && !dwb_ack_i) begin sena = 1'b1; xopc = 5'h00; xea = $urandom; end
      #1;
      chk("busy_stall", lsu_stall, dwb_ack_i ? 0 : 1);
      chk("busy_adr", dwb_adr_o, v.ea >> 2);
      chk("busy_cyc", dwb_cyc_o, 1);
      @(posedge sclk); #1;
      sena = 1'b0; xopc = 5'h1F;
      if (k == v.waits) break;
    end
    dwb_ack_i = 1'b0;
    expd = v.ld ? v.md : mdat_m;
    if (v.ld) mdat_m = v.md;
    chk("end_cyc", dwb_cyc_o, 0);
    chk("end_stb", dwb_stb_o, 0);
    chk("end_stall", lsu_stall, 0);
    chk("end_mld", mld, v.ld);
    chk("end_mexc", mexc, v.exc);
    chk("end_mdat", mdat, expd);
    @(posedge sclk); #1;
    chk("pulse_mld", mld, 0);
    chk("pulse_mexc", mexc, 0);
  endtask

  vec_t tbl[13];

  initial begin
    vec_t v;
    int r;
    logic [4:0] opc;

    //           opc    fn3     ea            xd            rd            w  k  sel      md            ld    exc
    tbl[0]  = '{5'h00, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 1, 2, 4'b1000, 32'hFFFF_FF80, 1'b1, 2'b00};
    tbl[1]  = '{5'h00, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 2, 4'b1100, 32'h0000_BEEF, 1'b1, 2'b00};
    tbl[2]  = '{5'h00, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 2, 4'b1100, 32'hFFFF_BEEF, 1'b1, 2'b00};
    tbl[3]  = '{5'h08, 3'b001, 32'h0000_2002, 32'hBEEF_BEEF, 32'h0,        3, 2, 4'b1100, 32'h0,         1'b0, 2'b00};
    tbl[4]  = '{5'h00, 3'b010, 32'h0000_1001, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,         1'b0, 2'b01};
    tbl[5]  = '{5'h08, 3'b010, 32'h0000_3000, 32'h1234_5678, 32'h0,        9, 2, 4'b1111, 32'h0,         1'b0, 2'b10};
    tbl[6]  = '{5'h00, 3'b100, 32'h0000_4001, 32'h0,        32'h1234_8765, 2, 2, 4'b0010, 32'h0000_0087, 1'b1, 2'b00};
    tbl[7]  = '{5'h00, 3'b010, 32'h0000_5000, 32'h0,        32'hDEAD_BEEF, 2, 2, 4'b1111, 32'hDEAD_BEEF, 1'b1, 2'b00};
    tbl[8]  = '{5'h08, 3'b000, 32'h0000_6002, 32'hA5A5_A5A5, 32'h0,        0, 2, 4'b0100, 32'h0,         1'b0, 2'b00};
    tbl[9]  = '{5'h00, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,         1'b0, 2'b01};
    tbl[10] = '{5'h08, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,         1'b0, 2'b01};
    tbl[11] = '{5'h00, 3'b001, 32'h0000_7001, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,         1'b0, 2'b01};
    tbl[12] = '{5'h00, 3'b010, 32'h0000_8000, 32'h0,        32'h1111_2222, 7, 2, 4'b1111, 32'h0,         1'b0, 2'b10};

    // Reset state
    #2;
    chk("rst_cyc", dwb_cyc_o, 0);
    chk("rst_stb", dwb_stb_o, 0);
    chk("rst_mdat", mdat, 0);
    chk("rst_mld", mld, 0);
    chk("rst_mexc", mexc, 0);
    chk("rst_stall", lsu_stall, 0);
    chk("rst_sel", dwb_sel_o, 0);
    @(negedge sclk); srst = 1'b1;
    @(posedge sclk); #1;

    // Ack while idle is ignored
    dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge sclk); #1;
      chk("idleack_mld", mld, 0);
      chk("idleack_stall", lsu_stall, 0);
      chk("idleack_cyc", dwb_cyc_o, 0);
    end
    dwb_ack_i = 1'b0;
    chk("idleack_mdat", mdat, 0);

    // Directed table
    for (int i = 0; i < 13; i++) run(tbl[i], 1'b0);

    // Randomized accesses against the reference model
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) opc = 5'h00;
      else if (r < 8) opc = 5'h08;
      else opc = 5'($urandom_range(1, 31));
      if (opc == 5'h08 && r >= 8) opc = 5'h0C;
      v = model(opc, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 5)));
      run(v, 1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-transfer drops the bus immediately
    @(negedge sclk);
    sena = 1'b1; xopc = 5'h08; xfn3 = 3'b010; xea = 32'h0000_9000; xdat = 32'h5555_AAAA;
    @(posedge sclk); #1;
    sena = 1'b0; xopc = 5'h1F;
    chk("mid_cyc_before", dwb_cyc_o, 1);
    #2 srst = 1'b0;
    #1;
    chk("mid_cyc", dwb_cyc_o, 0);
    chk("mid_stb", dwb_stb_o, 0);
    chk("mid_stall", lsu_stall, 0);
    @(negedge sclk); srst = 1'b1;
    @(posedge sclk); #1;
    chk("post_cyc", dwb_cyc_o, 0);
    chk("post_mdat", mdat, 0);
    mdat_m = '0;
    run(tbl[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
